// File: rtl/cim_array_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cim_array_ctrl_pkg
//   Shared widths and the bank-select encoding for the write-path front end
//   of the dual-bank CIM macro array.
//   - CIM_DATA_W : width of the write data word
//   - CIM_ADDR_W : width of the word address / wordline select
//   - cim_bank_e : bank-select encoding carried on cima
// ---------------------------------------------------------------------------
package cim_array_ctrl_pkg;

  localparam int CIM_DATA_W = 24;
  localparam int CIM_ADDR_W = 8;

  typedef enum logic {
    CIM_BANK0 = 1'b0,
    CIM_BANK1 = 1'b1
  } cim_bank_e;

endpackage : cim_array_ctrl_pkg

// File: rtl/cim_array_ctrl_bank_demux.sv
// ---------------------------------------------------------------------------
// cim_bank_demux
//   Combinational steering of one word address onto exactly one of the two
//   bank address buses. The unselected bank always sees zero. When guard is
//   high both banks see zero (break-before-make window on a bank switch).
//   Ports:
//     addr  in   ADDR_W  word address to steer
//     sel   in   1       bank select (CIM_BANK0 / CIM_BANK1)
//     guard in   1       force both outputs to zero
//     a0    out  ADDR_W  bank-0 address
//     a1    out  ADDR_W  bank-1 address
// ---------------------------------------------------------------------------
module cim_bank_demux
  import cim_array_ctrl_pkg::*;
#(
  parameter int ADDR_W = CIM_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              sel,
  input  logic              guard,
  output logic [ADDR_W-1:0] a0,
  output logic [ADDR_W-1:0] a1
);

  // Both banks default to zero so that at most one bus is ever non-zero.
  always_comb begin
    a0 = '0;
    a1 = '0;
    if (!guard) begin
      if (sel == CIM_BANK1) begin
        a1 = addr;
      end else begin
        a0 = addr;
      end
    end
  end

endmodule : cim_bank_demux

// File: rtl/cim_array_ctrl.sv
// ---------------------------------------------------------------------------
// cim_array_ctrl
//   Write-path front end of the dual-bank CIM macro array. Registers the
//   host write word onto the shared D1 bus and steers the word address to
//   the selected bank only. All outputs are registered, 1-cycle latency.
//   Optional build macro: CIM_ARRAY_CTRL_BANK_GUARD_EN
//     When defined, a bank switch inserts one cycle where both bank
//     addresses are zero (break-before-make).
//   Ports:
//     clk   in   1       clock, all state on rising edge
//     rst   in   1       synchronous active-high reset
//     D     in   DATA_W  write data from host
//     WA    in   ADDR_W  word address from host
//     cima  in   1       bank select: 0 = bank 0, 1 = bank 1
//     D1    out  DATA_W  registered write data, shared by both banks
//     WA0   out  ADDR_W  registered bank-0 address
//     WA1   out  ADDR_W  registered bank-1 address
// ---------------------------------------------------------------------------
module cim_array_ctrl
  import cim_array_ctrl_pkg::*;
#(
  parameter int DATA_W = CIM_DATA_W,
  parameter int ADDR_W = CIM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] WA,
  input  logic              cima,
  output logic [DATA_W-1:0] D1,
  output logic [ADDR_W-1:0] WA0,
  output logic [ADDR_W-1:0] WA1
);

  logic [DATA_W-1:0] d1_d,  d1_q;
  logic [ADDR_W-1:0] wa0_d, wa0_q;
  logic [ADDR_W-1:0] wa1_d, wa1_q;
  logic              guard;

`ifdef CIM_ARRAY_CTRL_BANK_GUARD_EN
  logic prev_cima_d, prev_cima_q;

  // A change of bank relative to the last sampled select opens the
  // guard window for this edge; the copy itself tracks cima every edge.
  always_comb begin
    prev_cima_d = cima;
    guard       = (cima != prev_cima_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cima_q <= CIM_BANK0;
    end else begin
      prev_cima_q <= prev_cima_d;
    end
  end
`else
  assign guard = 1'b0;
`endif

  cim_bank_demux #(
    .ADDR_W (ADDR_W)
  ) u_bank_demux (
    .addr  (WA),
    .sel   (cima),
    .guard (guard),
    .a0    (wa0_d),
    .a1    (wa1_d)
  );

  // The data word is shared by both banks, so it is copied regardless of
  // bank select or guard state.
  always_comb begin
    d1_d = D;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q  <= '0;
      wa0_q <= '0;
      wa1_q <= '0;
    end else begin
      d1_q  <= d1_d;
      wa0_q <= wa0_d;
      wa1_q <= wa1_d;
    end
  end

  assign D1  = d1_q;
  assign WA0 = wa0_q;
  assign WA1 = wa1_q;

endmodule : cim_array_ctrl

// File: tb/tb_cim_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cim_array_ctrl
//   Self-checking bench for cim_array_ctrl: directed cases followed by
//   randomized traffic compared against a behavioural 1-cycle model.
//   Honours CIM_ARRAY_CTRL_BANK_GUARD_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_cim_array_ctrl;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] D;
  logic [ADDR_W-1:0] WA;
  logic              cima;
  logic [DATA_W-1:0] D1;
  logic [ADDR_W-1:0] WA0;
  logic [ADDR_W-1:0] WA1;

  int checkCount;
  int passCount;

  // Reference model state: what the outputs should read after the last edge.
  logic [DATA_W-1:0] expD1;
  logic [ADDR_W-1:0] expWa0;
  logic [ADDR_W-1:0] expWa1;
  logic              prevCima;

  cim_array_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .D    (D),
    .WA   (WA),
    .cima (cima),
    .D1   (D1),
    .WA0  (WA0),
    .WA1  (WA1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a mismatch on a single line.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model of one rising edge, expressed from the block's rules.
  task automatic modelEdge(input logic r, input logic [DATA_W-1:0] d,
                           input logic [ADDR_W-1:0] wa, input logic c);
    logic switching;
    if (r) begin
      expD1    = '0;
      expWa0   = '0;
      expWa1   = '0;
      prevCima = 1'b0;
    end else begin
`ifdef CIM_ARRAY_CTRL_BANK_GUARD_EN
      switching = (c != prevCima);
`else
      switching = 1'b0;
`endif
      expD1    = d;
      expWa0   = (switching || c) ? '0 : wa;
      expWa1   = (switching || !c) ? '0 : wa;
      prevCima = c;
    end
  endtask

  // Drive inputs away from the edge, take one edge, then compare.
  task automatic applyStimulus(input logic r, input logic [DATA_W-1:0] d,
                               input logic [ADDR_W-1:0] wa, input logic c);
    @(negedge clk);
    rst  = r;
    D    = d;
    WA   = wa;
    cima = c;
    @(posedge clk);
    modelEdge(r, d, wa, c);
    #1;
    checkOutput("d1",  32'(D1),  32'(expD1));
    checkOutput("wa0", 32'(WA0), 32'(expWa0));
    checkOutput("wa1", 32'(WA1), 32'(expWa1));
    checkOutput("bank_excl", {31'b0, (WA0 != '0) && (WA1 != '0)}, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    expD1      = '0;
    expWa0     = '0;
    expWa1     = '0;
    prevCima   = 1'b0;
    rst        = 1'b1;
    D          = '0;
    WA         = '0;
    cima       = 1'b0;

    // Reset held for two edges with all-ones inputs.
    applyStimulus(1'b1, 24'hFFFFFF, 8'hFF, 1'b0);
    applyStimulus(1'b1, 24'hFFFFFF, 8'hFF, 1'b0);
    checkOutput("rst_d1",  32'(D1),  32'h000000);
    checkOutput("rst_wa0", 32'(WA0), 32'h00);
    checkOutput("rst_wa1", 32'(WA1), 32'h00);

    // Bank 0 write.
    applyStimulus(1'b0, 24'hABCDEF, 8'hA5, 1'b0);
    checkOutput("b0_d1",  32'(D1),  32'hABCDEF);
    checkOutput("b0_wa0", 32'(WA0), 32'hA5);
    checkOutput("b0_wa1", 32'(WA1), 32'h00);

    // Switch to bank 1.
    applyStimulus(1'b0, 24'h123456, 8'h5A, 1'b1);
    checkOutput("b1_d1",  32'(D1),  32'h123456);
    checkOutput("b1_wa0", 32'(WA0), 32'h00);
`ifdef CIM_ARRAY_CTRL_BANK_GUARD_EN
    checkOutput("b1_guard_wa1", 32'(WA1), 32'h00);
    applyStimulus(1'b0, 24'h123456, 8'h5A, 1'b1);
    checkOutput("b1_wa1", 32'(WA1), 32'h5A);
`else
    checkOutput("b1_wa1", 32'(WA1), 32'h5A);
`endif

    // All-ones on bank 0, then mid-stream reset.
    applyStimulus(1'b0, 24'hFFFFFF, 8'hFF, 1'b0);
    applyStimulus(1'b0, 24'hFFFFFF, 8'hFF, 1'b0);
    checkOutput("ones_d1",  32'(D1),  32'hFFFFFF);
    checkOutput("ones_wa0", 32'(WA0), 32'hFF);
    checkOutput("ones_wa1", 32'(WA1), 32'h00);
    applyStimulus(1'b1, 24'hFFFFFF, 8'hFF, 1'b0);
    checkOutput("mid_rst_d1",  32'(D1),  32'h0);
    checkOutput("mid_rst_wa0", 32'(WA0), 32'h0);
    checkOutput("mid_rst_wa1", 32'(WA1), 32'h0);

    // First edge after reset loads the live inputs.
    applyStimulus(1'b0, 24'hC0FFEE, 8'hC3, 1'b0);
    checkOutput("post_rst_d1",  32'(D1),  32'hC0FFEE);
    checkOutput("post_rst_wa0", 32'(WA0), 32'hC3);
    applyStimulus(1'b0, 24'hC0FFEE, 8'hC3, 1'b1);
    checkOutput("toggle_d1",  32'(D1),  32'hC0FFEE);
    checkOutput("toggle_wa0", 32'(WA0), 32'h00);
`ifndef CIM_ARRAY_CTRL_BANK_GUARD_EN
    checkOutput("toggle_wa1", 32'(WA1), 32'hC3);
`endif

    // WA = 0 leaves both banks at zero.
    applyStimulus(1'b0, 24'h000001, 8'h00, 1'b1);
    checkOutput("zero_wa0", 32'(WA0), 32'h00);
    checkOutput("zero_wa1", 32'(WA1), 32'h00);

    // Per-cycle cima toggling.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 24'($urandom), 8'($urandom_range(1, 255)), 1'(i % 2));
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 3), 24'($urandom), 8'($urandom),
                    1'($urandom));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_cim_array_ctrl
